// File: rtl/vram_port_arbiter.sv
// Single-port VRAM/register BRAM arbiter: video scan-out has priority,
// host gets a guaranteed slot after STARVE_MAX consecutive video grants.
module vram_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 601,
    parameter int STARVE_MAX = 4
) (
    input  logic                axi_aclk,
    input  logic                axi_aresetn,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic                vid_gnt,
    output logic                vid_rvalid,
    output logic [DATA_W-1:0]   vid_rdata,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    input  logic [DATA_W/8-1:0] host_wstrb,
    output logic                host_gnt,
    output logic                host_done,
    output logic [DATA_W-1:0]   host_rdata,
    output logic                host_err,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {H_IDLE, H_WR, H_RD, H_RD2} hstate_t;

    hstate_t     state;
    hstate_t     state_nxt;
    logic [3:0]  starve_cnt;
    logic        host_pend;
    logic        host_win;
    logic        vid_win;
    logic        host_oor;
    logic        vid_v1;

    // Arbitration
    always_comb begin
        host_oor  = {1'b0, host_addr} >= DEPTH_L;
        host_pend = host_req && (state == H_IDLE);
        host_win  = host_pend && (!vid_req || starve_cnt == SMAX);
        vid_win   = vid_req && !host_win;
    end

    // Grants and BRAM strobes are held low while reset is asserted
    always_comb begin
        host_gnt  = axi_aresetn && host_win;
        vid_gnt   = axi_aresetn && vid_win;
        bram_en   = axi_aresetn && (vid_win || (host_win && !host_oor));
        bram_we   = '0;
        if (axi_aresetn && host_win && host_we && !host_oor)
            bram_we = host_wstrb;
        bram_addr = host_win ? host_addr : vid_addr;
        bram_din  = host_wdata;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)
            starve_cnt <= '0;
        else if (!host_pend || host_win)
            starve_cnt <= '0;
        else if (vid_win && starve_cnt != SMAX)
            starve_cnt <= starve_cnt + 4'd1;
    end

    // Host FSM: state register
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)
            state <= H_IDLE;
        else
            state <= state_nxt;
    end

    // Host FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            H_IDLE: if (host_win) state_nxt = host_we ? H_WR : H_RD;
            H_WR:   state_nxt = H_IDLE;
            H_RD:   state_nxt = H_RD2;
            H_RD2:  state_nxt = H_IDLE;
            default: state_nxt = H_IDLE;
        endcase
    end

    // Host FSM: outputs
    always_comb begin
        host_done = (state == H_WR) || (state == H_RD2);
    end

    // Out-of-range reads return zero instead of BRAM contents
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            host_err   <= 1'b0;
            host_rdata <= '0;
        end else begin
            if (host_win)
                host_err <= host_oor;
            if (state == H_RD)
                host_rdata <= host_err ? '0 : bram_dout;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            vid_v1     <= 1'b0;
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
        end else begin
            vid_v1     <= vid_win;
            vid_rvalid <= vid_v1;
            if (vid_v1)
                vid_rdata <= bram_dout;
        end
    end

    logic unused_strb;
    assign unused_strb = ^{STRB_W{1'b0}};

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed + randomized bench for vram_port_arbiter with a BRAM model
// and a transaction-level reference (shadow memory, response queues).
module tb_vram_port_arbiter;

    localparam int DEPTH = 601;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic        vid_gnt;
    logic        vid_rvalid;
    logic [31:0] vid_rdata;
    logic        host_req;
    logic        host_we;
    logic [11:0] host_addr;
    logic [31:0] host_wdata;
    logic [3:0]  host_wstrb;
    logic        host_gnt;
    logic        host_done;
    logic [31:0] host_rdata;
    logic        host_err;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [11:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    always #5 clk = ~clk;

    vram_port_arbiter dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_wstrb (host_wstrb),
        .host_gnt   (host_gnt),
        .host_done  (host_done),
        .host_rdata (host_rdata),
        .host_err   (host_err),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout)
    );

    // BRAM model: read-first, 1-cycle latency, byte write enables
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (bram_en) begin
            bram_dout <= mem[bram_addr];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
        end
    end

    typedef struct {
        int          due;
        logic [31:0] d;
    } vexp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          host_free = 0;
    int          waited = 0;
    int          hd_cyc = -1;
    logic        hd_err;
    logic        hd_rd;
    logic [31:0] hd_data;
    logic [31:0] ref_mem [0:4095];
    vexp_t       vq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the reference, advance
    task automatic step(input logic vr, input logic [11:0] va,
                        input logic hr, input logic hwe, input logic [11:0] ha,
                        input logic [31:0] hwd, input logic [3:0] hs,
                        output logic hg);
        logic        pend, vg, oor, en, ev;
        logic [3:0]  we;
        vid_req = vr; vid_addr = va;
        host_req = hr; host_we = hwe; host_addr = ha;
        host_wdata = hwd; host_wstrb = hs;
        #2;
        pend = hr && (cyc >= host_free);
        hg   = pend && (!vr || waited == SMAX);
        vg   = vr && !hg;
        oor  = int'(ha) >= DEPTH;
        en   = vg || (hg && !oor);
        we   = (hg && hwe && !oor) ? hs : 4'h0;
        chk("host_gnt", 32'(host_gnt), 32'(hg));
        chk("vid_gnt", 32'(vid_gnt), 32'(vg));
        chk("bram_en", 32'(bram_en), 32'(en));
        chk("bram_we", 32'(bram_we), 32'(we));
        if (en) chk("bram_addr", 32'(bram_addr), 32'(hg ? ha : va));
        if (we != 0) chk("bram_din", bram_din, hwd);
        chk("host_done", 32'(host_done), 32'(hd_cyc == cyc));
        if (hd_cyc == cyc) begin
            chk("host_err", 32'(host_err), 32'(hd_err));
            if (hd_rd) chk("host_rdata", host_rdata, hd_data);
        end
        ev = (vq.size() > 0) && (vq[0].due == cyc);
        chk("vid_rvalid", 32'(vid_rvalid), 32'(ev));
        if (ev) begin
            chk("vid_rdata", vid_rdata, vq[0].d);
            void'(vq.pop_front());
        end
        if (!pend || hg) waited = 0;
        else if (vg && waited < SMAX) waited++;
        if (hg) begin
            hd_cyc    = cyc + (hwe ? 1 : 2);
            host_free = cyc + (hwe ? 2 : 3);
            hd_err    = oor;
            hd_rd     = !hwe;
            hd_data   = oor ? 32'h0 : ref_mem[ha];
            if (hwe && !oor)
                for (int b = 0; b < 4; b++)
                    if (hs[b]) ref_mem[ha][8*b +: 8] = hwd[8*b +: 8];
        end
        if (vg) vq.push_back('{cyc + 2, ref_mem[va]});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, g);
    endtask

    // Issue one host op, holding the request until granted
    task automatic host_op(input logic we, input logic [11:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic vid_on);
        logic g;
        logic [11:0] va;
        va = 12'd100;
        for (int i = 0; i < 40; i++) begin
            step(vid_on, va, 1, we, a, d, s, g);
            va++;
            if (g) break;
        end
        for (int i = 0; i < 4; i++) begin
            step(vid_on, va, 0, 0, 0, 0, 0, g);
            va++;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        vid_req = 1; host_req = 1; host_we = 1;
        host_addr = 0; host_wstrb = 4'hF; vid_addr = 0;
        #2;
        chk("rst_host_gnt", 32'(host_gnt), 0);
        chk("rst_vid_gnt", 32'(vid_gnt), 0);
        chk("rst_bram_en", 32'(bram_en), 0);
        chk("rst_bram_we", 32'(bram_we), 0);
        chk("rst_host_done", 32'(host_done), 0);
        chk("rst_vid_rvalid", 32'(vid_rvalid), 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_vid_rdata", vid_rdata, 0);
        chk("rst_host_err", 32'(host_err), 0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        vid_req = 0; host_req = 0;
        rst_n = 1'b1;
        hd_cyc = -1;
        vq.delete();
        host_free = cyc;
        waited = 0;
        chk("rst_starve_cnt", 32'(dut.starve_cnt), 0);
    endtask

    initial begin
        logic        g;
        logic        have_op;
        logic        op_we;
        logic [11:0] op_a;
        logic [31:0] op_d;
        logic [3:0]  op_s;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        bram_dout = 0;
        rst_n = 1'b0;
        #1;
        do_reset(3);
        idle(2);

        host_op(1, 12'd0, 32'h0401_0310, 4'hF, 0);
        host_op(0, 12'd0, 32'h0, 4'h0, 0);
        host_op(1, 12'd7, 32'hAABB_CCDD, 4'h5, 0);
        host_op(0, 12'd7, 32'h0, 4'h0, 0);

        // host read against continuous video traffic
        host_op(0, 12'd0, 32'h0, 4'h0, 1);
        host_op(1, 12'd600, 32'h1234_5678, 4'hF, 1);

        for (int a = 0; a < 10; a++) step(1, 12'(a), 0, 0, 0, 0, 0, g);
        idle(3);

        host_op(1, 12'd601, 32'hDEAD_BEEF, 4'hF, 0);
        host_op(0, 12'd601, 32'h0, 4'h0, 0);
        host_op(0, 12'd4095, 32'h0, 4'h0, 0);

        step(0, 0, 1, 0, 12'd5, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        do_reset(2);
        idle(4);
        host_op(0, 12'd5, 32'h0, 4'h0, 0);

        have_op = 0;
        op_we = 0; op_a = 0; op_d = 0; op_s = 0;
        for (int i = 0; i < 600; i++) begin
            if (!have_op && ($urandom % 3 == 0)) begin
                have_op = 1;
                op_we = 1'($urandom);
                op_a  = 12'($urandom_range(0, 610));
                op_d  = $urandom;
                op_s  = 4'($urandom);
            end
            step(($urandom % 4) != 0, 12'($urandom_range(0, 700)),
                 have_op, op_we, op_a, op_d, op_s, g);
            if (g) have_op = 0;
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
